// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// It scans four active-low segment codes (MM:SS, leftmost digit first) onto
// the shared cathode and anode pins. The four codes are captured once per
// frame so that a frame never mixes old and new digits.
// The driver also provides a colon dot on digit 1, leading-zero blanking of
// digit 0, and whole-display blinking.
//
// Parameters
//   DIGIT_CYCLES  clock cycles each digit is lit (>= 2)
//   BLINK_DIGITS  digit advances per blink half-period (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   seg1..seg4  digit 0..3 codes, active-low {g,f,e,d,c,b,a}
//   colon_en    light the separator dot (digit 1 dp)
//   blink_en    blank the display during odd blink phases
//   blank_lead  blank digit 0 while it shows "0"
//   an          anode enables, active-low, an[3] = digit 0
//   seg         segment cathodes, active-low {g,f,e,d,c,b,a}
//   dp          decimal point cathode, active-low
//   frame_done  one-cycle pulse after the last cycle of each frame
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLINK_DIGITS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    input  logic [6:0] seg4,
    input  logic       colon_en,
    input  logic       blink_en,
    input  logic       blank_lead,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int BW = (BLINK_DIGITS > 1) ? $clog2(BLINK_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIGITS - 1);
    localparam logic [6:0]    SEG_OFF   = 7'h7F;
    localparam logic [6:0]    SEG_ZERO  = 7'b1000000;

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [6:0]    sh_r [4];
    logic [BW-1:0] bcnt_r;
    logic          ph_r;
    logic          st_r;

    logic          adv_s;
    logic          wrap_s;
    logic          cap_s;
    logic          blink_s;
    logic [3:0]    an_s;
    logic [6:0]    seg_s;
    logic          dp_s;

    // Scan sequencing decodes and the next output value for the current digit.
    always_comb begin
        adv_s   = 1'b0;
        wrap_s  = 1'b0;
        cap_s   = 1'b0;
        blink_s = 1'b0;
        an_s    = 4'b1111;
        seg_s   = SEG_OFF;
        dp_s    = 1'b1;

        // The start cycle only captures; the prescaler is held so that digit 0
        // still gets its full DIGIT_CYCLES slot once the outputs light up.
        if (st_r) begin
            adv_s = 1'b0;
        end else begin
            adv_s = (cnt_r == CNT_LAST);
        end
        wrap_s  = adv_s && (idx_r == 2'd3);
        cap_s   = wrap_s || st_r;
        blink_s = blink_en && ph_r;

        case (idx_r)
            2'd0:    an_s = 4'b0111;
            2'd1:    an_s = 4'b1011;
            2'd2:    an_s = 4'b1101;
            2'd3:    an_s = 4'b1110;
            default: an_s = 4'b1111;
        endcase

        if (blink_s || (blank_lead && (idx_r == 2'd0) && (sh_r[0] == SEG_ZERO))) begin
            seg_s = SEG_OFF;
        end else begin
            seg_s = sh_r[idx_r];
        end

        if (colon_en && (idx_r == 2'd1) && !blink_s) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end
    end

    // Prescaler, digit index, blink phase, start flag and frame shadows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= '0;
            idx_r  <= 2'd0;
            bcnt_r <= '0;
            ph_r   <= 1'b0;
            st_r   <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                sh_r[i] <= SEG_OFF;
            end
        end else begin
            st_r <= 1'b0;
            if (st_r) begin
                cnt_r <= cnt_r;
            end else if (adv_s) begin
                cnt_r <= '0;
                idx_r <= idx_r + 2'd1;
                // Phase keeps running with blinking disabled so that enabling
                // blink never restarts the half-period.
                if (bcnt_r == BCNT_LAST) begin
                    bcnt_r <= '0;
                    ph_r   <= ~ph_r;
                end else begin
                    bcnt_r <= bcnt_r + BW'(1);
                end
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (cap_s) begin
                sh_r[0] <= seg1;
                sh_r[1] <= seg2;
                sh_r[2] <= seg3;
                sh_r[3] <= seg4;
            end
        end
    end

    // Output register: dark in reset and on the start cycle, otherwise it
    // shows the digit selected on the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else if (st_r) begin
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_s;
            seg        <= seg_s;
            dp         <= dp_s;
            frame_done <= wrap_s;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the 4-digit common-anode 7-segment display on the parking-system board. It consumes the four per-digit segment codes produced by the parking timer's time-to-7-segment conversion (MM:SS, leftmost digit first). It scans them onto the shared segment and anode pins, with frame-synchronous input capture, a colon dot, leading-zero blanking and whole-display blinking. It is the display-side end of the time/segment interface; each instance owns the physical pins.

## Interface
- DIGIT_CYCLES, 100000: clock cycles each digit is lit (1 ms at 100 MHz); must be ≥2.
- BLINK_DIGITS, 250: digit advances per blink half-period (250 ms at defaults); must be ≥1.

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seg1  in  7  digit 0 code (tens of minutes), active-low, bit order {g,f,e,d,c,b,a}.
- seg2  in  7  digit 1 code (minutes), same encoding.
- seg3  in  7  digit 2 code (tens of seconds), same encoding.
- seg4  in  7  digit 3 code (seconds), same encoding.
- colon_en  in  1  light the MM:SS separator dot.
- blink_en  in  1  blank the display during odd blink phases.
- blank_lead  in  1  blank digit 0 when it shows "0".
- an  out  4  anode enables, active-low; an[3] = digit 0, an[0] = digit 3.
- seg  out  7  segment cathodes, active-low, {g,f,e,d,c,b,a}.
- dp  out  1  decimal point cathode, active-low.
- frame_done  out  1  one-cycle pulse at the end of each 4-digit frame.

## Operation
- **State:**
  - prescaler cnt, 0..DIGIT_CYCLES-1;
  - digit index idx, 0..3;
  - four 7-bit shadow registers sh0..sh3;
  - blink counter bcnt, 0..BLINK_DIGITS-1;
  - blink phase ph;
  - start flag st.
- **Reset values:**
  - cnt=0, idx=0, bcnt=0, ph=0, st=1;
  - sh0..sh3=7'h7F;
  - an=4'b1111, seg=7'h7F, dp=1, frame_done=0.
- **Digit advance:** when cnt==DIGIT_CYCLES-1, cnt←0 and idx←idx+1 (mod 4). Otherwise cnt increments.
- **Frame capture:** sh0..sh3 ← seg1..seg4 on either of these cycles:
  - the wrap cycle (cnt==DIGIT_CYCLES-1 and idx==3);
  - the cycle where st==1, after which st←0.
- **Mid-frame input changes:** not displayed until the next capture. This prevents tearing.
- **Blink:** on every digit advance, bcnt increments. At BLINK_DIGITS-1, bcnt←0 and ph toggles.
  - ph runs whether or not blink_en is set.
- **Output register:** loaded every cycle from the current idx and the shadows.
  - an = one-hot-low for idx: idx0→4'b0111, idx1→4'b1011, idx2→4'b1101, idx3→4'b1110.
  - seg = sh[idx]. Two conditions force seg=7'h7F instead:
    - blank_lead==1, idx==0 and sh0==7'b1000000 ("0");
    - blink_en==1 and ph==1.
  - dp = 0 only when colon_en==1, idx==1 and the display is not blink-blanked; otherwise dp=1.
  - During blink blanking, an keeps rotating. This keeps the brightness duty constant.
- **frame_done:** registered; asserts for the one cycle following the wrap cycle.
- **Reset mid-frame:** asynchronous. All state returns to reset values immediately and outputs go dark the same instant. After release, the display restarts at digit 0 with a fresh capture.

## Timing
- The output register adds 1 cycle: an/seg/dp reflect the idx/shadow state of the previous cycle.
- **First cycle after reset release:** capture occurs and outputs are still dark. On the next edge an=4'b0111 with seg=seg1 as captured.
- Each digit is lit for exactly DIGIT_CYCLES cycles. A frame is 4·DIGIT_CYCLES cycles.
- The frame_done period is 4·DIGIT_CYCLES. The first pulse comes 4·DIGIT_CYCLES cycles after the first capture.
- The blink half-period is BLINK_DIGITS·DIGIT_CYCLES cycles.
- colon_en, blink_en and blank_lead take effect 1 cycle after they change; they are not frame-synchronous.
- Inputs sampled on the wrap cycle are shown starting from the next digit-0 slot. An input change on exactly the wrap cycle is captured.

## Test plan
Bench parameters: DIGIT_CYCLES=4, BLINK_DIGITS=2.

1. **Reset and first frame.** Hold rst, then release with seg1..seg4=40,79,24,30 (hex).
   - During reset: an=F, seg=7F, dp=1.
   - After release: an goes 7,B,D,E, each for 4 cycles, with seg=40,79,24,30.
   - frame_done pulses every 16 cycles.
2. **Tearing guard.** Change seg3 from 24 to 12 while idx==1.
   - The current frame still shows 24 in the an=D slot.
   - The next frame shows 12.
3. **Leading-zero blank.** Set blank_lead=1 with seg1=40.
   - In the an=7 slot, seg=7F.
   - Set seg1=79: the an=7 slot shows seg=79 from the next frame.
4. **Colon.** Set colon_en=1.
   - dp=0 only during the an=B slot; dp=1 in all other slots.
5. **Blink.** Set blink_en=1 with colon_en=1.
   - seg=7F and dp=1 for 8 cycles, then normal digits for 8 cycles, alternating.
   - an keeps rotating throughout.
6. **Mid-frame reset.** Assert rst during the an=D slot.
   - Outputs go dark asynchronously.
   - After release, the scan resumes at an=7 with newly captured inputs.
